// File: rtl/adc_spi_reader.sv
// SPI master for a serial ADC: frames cs_n, divides clk down to sclk, shifts in
// miso MSB first and hands each result to a valid/ready consumer with sticky overrun.
module adc_spi_reader #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned LEAD_BITS  = 3,
  parameter int unsigned HALF_DIV   = 500,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  cs_n,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  overrun
);
  localparam int unsigned TOTAL_BITS = LEAD_BITS + DATA_WIDTH;
  localparam int unsigned GAP_TICKS  = 2 * GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(HALF_DIV);
  localparam int unsigned BIT_W      = $clog2(TOTAL_BITS + 1);
  localparam int unsigned GAP_W      = $clog2(GAP_TICKS);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  load;
  logic                  tick_c, last_bit_c, rise_c, shift_done_c, gap_done_c;

  // Lead bits simply fall off the top of the DATA_WIDTH-wide shift register.
  always_comb begin
    tick_c       = (state != IDLE) && (div_cnt == CNT_W'(HALF_DIV - 1));
    last_bit_c   = (bit_cnt == BIT_W'(TOTAL_BITS));
    rise_c       = tick_c && !sclk &&
                   ((state == SETUP) || ((state == SHIFT) && !last_bit_c));
    shift_done_c = tick_c && !sclk && (state == SHIFT) && last_bit_c;
    gap_done_c   = tick_c && (state == GAP) && (gap_cnt == GAP_W'(GAP_TICKS - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start || continuous) state_nx = SETUP;
      SETUP:   if (tick_c) state_nx = SHIFT;
      SHIFT:   if (shift_done_c) state_nx = GAP;
      GAP:     if (gap_done_c) state_nx = continuous ? SETUP : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Divider, bit/gap counters, serial pins and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      busy    <= 1'b0;
      load    <= 1'b0;
    end else begin
      if ((state == IDLE) || (state_nx == IDLE) || tick_c) div_cnt <= '0;
      else                                                 div_cnt <= div_cnt + CNT_W'(1);

      if ((state == IDLE) || (state == GAP)) bit_cnt <= '0;
      else if (rise_c)                       bit_cnt <= bit_cnt + BIT_W'(1);

      if (state != GAP) gap_cnt <= '0;
      else if (tick_c)  gap_cnt <= gap_cnt + GAP_W'(1);

      if ((state_nx == SETUP) && (state != SETUP)) shreg <= '0;
      else if (rise_c)                             shreg <= {shreg[DATA_WIDTH-2:0], miso};

      if (rise_c)      sclk <= 1'b1;
      else if (tick_c) sclk <= 1'b0;

      cs_n <= (state_nx == IDLE) || (state_nx == GAP);
      busy <= (state_nx != IDLE);
      load <= (state == SHIFT) && (state_nx == GAP);
    end
  end

  // Result hand-off: a load always wins over a same-cycle acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (load) begin
      sample       <= shreg;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end
endmodule
